// File: rtl/seq_divider.sv
// seq_divider: multicycle signed restoring divider; optional divide-by-zero trap via SEQ_DIVIDER_DIV0_TRAP_EN
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t          state, state_nx;
  logic [WIDTH-1:0] dvd, dvs;
  logic [WIDTH:0]   rem, shifted, trial;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r, ge;
  assign busy    = state != IDLE;
  assign shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign ge      = shifted >= {1'b0, dvs};
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next state; a zero divisor short-circuits to DONE when the trap is built in
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? CALC : IDLE;
`ifdef SEQ_DIVIDER_DIV0_TRAP_EN
      CALC: state_nx = dvs == '0 ? DONE : count == CW'(1) ? FIX : CALC;
`else
      CALC: state_nx = count == CW'(1) ? FIX : CALC;
`endif
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
`ifdef SEQ_DIVIDER_DIV0_TRAP_EN
  // divide-by-zero flag: cleared on accept, raised when CALC sees a zero divisor
  always_ff @(posedge clk or negedge reset)
    if (!reset) div_by_zero <= 1'b0;
    else if (state == IDLE && start) div_by_zero <= 1'b0;
    else if (state == CALC && dvs == '0) div_by_zero <= 1'b1;
`else
  assign div_by_zero = 1'b0;
`endif
  // datapath: latch magnitudes on accept, one restoring step per CALC cycle, sign fix-up in FIX
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      count     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          dvd    <= a[WIDTH-1] ? -a : a;
          dvs    <= b[WIDTH-1] ? -b : b;
          sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
          sign_r <= a[WIDTH-1];
          rem    <= '0;
          count  <= CW'(WIDTH);
        end
        CALC: begin
          rem   <= ge ? trial : shifted;
          dvd   <= {dvd[WIDTH-2:0], ge};
          count <= count - CW'(1);
`ifdef SEQ_DIVIDER_DIV0_TRAP_EN
          if (dvs == '0) done <= 1'b1;
`endif
        end
        FIX: begin
          quotient  <= sign_q ? -dvd : dvd;
          remainder <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          done      <= 1'b1;
        end
        DONE: done <= 1'b0;
        default: done <= 1'b0;
      endcase
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (WIDTH=32)
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        start = 1'b0;
  logic [31:0] quotient, remainder;
  logic        done, busy, div_by_zero;
  int          checks = 0, errors = 0;
  int          n, pulses;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .start(start),
    .quotient(quotient), .remainder(remainder), .done(done),
    .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1 cnt++;
    end while (!done && cnt < 100);
  endtask

  task automatic run(input string tag, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eq, input logic [31:0] er);
    int c;
    start_op(av, bv);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(c);
    check({tag, "_lat"}, 32'(c), 32'd33);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1 check({tag, "_done_end"}, 32'(done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run("pos", 32'd100, 32'd7, 32'd14, 32'd2);
    run("negdvd", -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("negdvs", 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1);
    run("minneg", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    run("pre0", 32'd100, 32'd7, 32'd14, 32'd2);
    start_op(32'd5, 32'd0);
    wait_done(n);
`ifdef SEQ_DIVIDER_DIV0_TRAP_EN
    check("div0_lat", 32'(n), 32'd1);
    check("div0_dz", 32'(div_by_zero), 32'd1);
    check("div0_q", quotient, 32'd14);
    check("div0_r", remainder, 32'd2);
`else
    check("div0_lat", 32'(n), 32'd33);
    check("div0_dz", 32'(div_by_zero), 32'd0);
    check("div0_q", quotient, 32'hFFFF_FFFF);
    check("div0_r", remainder, 32'd5);
`endif
    @(posedge clk);
    #1 check("div0_busy_end", 32'(busy), 32'd0);

    start_op(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run("postrst", 32'd9, 32'd3, 32'd3, 32'd0);

    start_op(32'd100, 32'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 32'd50;
    b = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    check("busy_lat", 32'(n + 5), 32'd33);
    check("busy_q", quotient, 32'd14);
    check("busy_r", remainder, 32'd2);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    check("busy_no_second", 32'(pulses), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
